// File: rtl/mc_fifo_mem.sv
// Multi-channel synchronous FIFO: NUM_CH independent queues sharing one storage array,
// with per-channel pointers/counts, status flags, registered read data and OVF/UDF pulses.

module mc_fifo_ch #(
  parameter int ADDR_WIDTH = 3,
  parameter int AFULL_LVL  = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_acc,
  input  logic                  rd_acc,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  full,
  output logic                  empty,
  output logic                  afull
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [ADDR_WIDTH:0] count;

  // flush wins over any access the top let through on this channel
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty = (count == '0);
  assign afull = (count >= (ADDR_WIDTH+1)'(AFULL_LVL));
endmodule

module mc_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_CH     = 4,
  parameter int CH_WIDTH   = 2,
  parameter int AFULL_LVL  = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [CH_WIDTH-1:0]   WR_CH,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_EN,
  input  logic [CH_WIDTH-1:0]   RD_CH,
  input  logic [NUM_CH-1:0]     FLUSH,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic [NUM_CH-1:0]     FULL,
  output logic [NUM_CH-1:0]     EMPTY,
  output logic [NUM_CH-1:0]     AFULL,
  output logic                  OVF,
  output logic                  UDF
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:NUM_CH*DEPTH-1];

  logic [NUM_CH-1:0]                 wr_sel, rd_sel, wr_acc, rd_acc;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0]             wa, ra;
  logic                              wr_in_range, rd_in_range, ovf_d, udf_d;

  assign wr_in_range = (32'(WR_CH) < NUM_CH);
  assign rd_in_range = (32'(RD_CH) < NUM_CH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_sel[c] = WR_EN && (WR_CH == CH_WIDTH'(c));
    assign rd_sel[c] = RD_EN && (RD_CH == CH_WIDTH'(c));

    mc_fifo_ch #(.ADDR_WIDTH(ADDR_WIDTH), .AFULL_LVL(AFULL_LVL)) u_ch (
      .CLK    (CLK),
      .RST    (RST),
      .wr_acc (wr_acc[c]),
      .rd_acc (rd_acc[c]),
      .flush  (FLUSH[c]),
      .wr_ptr (wr_ptr[c]),
      .rd_ptr (rd_ptr[c]),
      .full   (FULL[c]),
      .empty  (EMPTY[c]),
      .afull  (AFULL[c])
    );
  end

  // Decisions use pre-edge flags, so a full channel still drains and an empty one
  // still fills in the same cycle; flushed channels see neither access nor error.
  assign wr_acc = wr_sel & ~FLUSH & ~FULL;
  assign rd_acc = rd_sel & ~FLUSH & ~EMPTY;
  assign ovf_d  = WR_EN & (~wr_in_range | (|(wr_sel & ~FLUSH & FULL)));
  assign udf_d  = RD_EN & (~rd_in_range | (|(rd_sel & ~FLUSH & EMPTY)));

  always_comb begin
    wa = '0;
    ra = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_sel[c]) wa = wr_ptr[c];
      if (rd_sel[c]) ra = rd_ptr[c];
    end
  end

  always_ff @(posedge CLK) begin
    if (|wr_acc) mem[{WR_CH, wa}] <= WR_DATA;
  end

  // Accepted reads never alias the word being written: same-channel collision
  // would need count 0 or D, where one side is always rejected.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
      OVF      <= 1'b0;
      UDF      <= 1'b0;
    end else begin
      if (|rd_acc) RD_DATA <= mem[{RD_CH, ra}];
      RD_VALID <= |rd_acc;
      OVF      <= ovf_d;
      UDF      <= udf_d;
    end
  end
endmodule
